fnd_scan_controller: RTL and testbench

Sequencer that drives the 4-digit FND BCD-to-segment decoder in time-multiplexed scan. It accepts a 14-bit binary value through a load handshake and converts it to 4 BCD digits with a sequential double-dabble engine. It holds the result in a display register and cycles the digit select at a programmable rate. It supplies the digit-select, BCD value and enable inputs of the decoder, including leading-zero blanking.

---
 rtl/fnd_scan_if.sv | 24 ++
 rtl/fnd_scan_controller.sv | 119 +++++++++++
 tb/tb_fnd_scan_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_if.sv
// Load/display bundle between a host (master) and the FND scan controller (slave).
// The slave takes in a binary value with a load handshake and drives the digit-select, BCD and enable inputs of the decoder.
interface fnd_scan_if #(
  parameter int BIN_W = 14
);
  logic [BIN_W-1:0] i_value;
  logic             i_load;
  logic             i_blankEn;
  logic             o_busy;
  logic             o_overflow;
  logic [1:0]       o_digitSelect;
  logic [3:0]       o_value;
  logic             o_en;

  modport master (
    output i_value, i_load, i_blankEn,
    input  o_busy, o_overflow, o_digitSelect, o_value, o_en
  );

  modport slave (
    input  i_value, i_load, i_blankEn,
    output o_busy, o_overflow, o_digitSelect, o_value, o_en
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// Converts a loaded binary value (0..9999) to four BCD digits with a sequential double-dabble engine.
// Time-multiplexes those digits onto the FND decoder, with optional leading-zero blanking.
module fnd_scan_controller #(
  parameter int CLK_DIV = 100000,
  parameter int BIN_W   = 14
) (
  input  logic       i_clk,
  input  logic       i_reset,
  fnd_scan_if.slave  bus
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
  localparam logic [BIN_W-1:0] VAL_MAX = BIN_W'(9999);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

  state_t           r_state;
  logic [15:0]      r_scratch;
  logic [BIN_W-1:0] r_bin;
  logic [3:0]       r_cnt;
  logic             r_busy;
  logic             r_ovf_pending;
  logic             r_overflow;
  logic [15:0]      r_display;

  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_idx;
  logic [3:0]       r_out_value;
  logic             r_zero_hi;

  logic [15:0]          w_adj;
  logic [16+BIN_W-1:0]  w_shifted;
  logic [BIN_W-1:0]     w_clamped;
  logic                 w_wrap;
  logic [1:0]           w_idx_next;
  logic [3:0]           w_zero_from;

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= 4'd5) ?
                                (r_scratch[gi*4 +: 4] + 4'd3) : r_scratch[gi*4 +: 4];
      assign w_zero_from[gi]  = (r_display[15:gi*4] == '0);
    end
  endgenerate

  assign w_shifted = {w_adj[14:0], r_bin, 1'b0};
  assign w_clamped = (bus.i_value > VAL_MAX) ? VAL_MAX : bus.i_value;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_scratch     <= '0;
      r_bin         <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_ovf_pending <= 1'b0;
      r_overflow    <= 1'b0;
      r_display     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_load) begin
            r_bin         <= w_clamped;
            r_ovf_pending <= (bus.i_value > VAL_MAX);
            r_scratch     <= '0;
            r_cnt         <= 4'd14;
            r_busy        <= 1'b1;
            r_state       <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          {r_scratch, r_bin} <= w_shifted;
          r_cnt              <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_display  <= r_scratch;
          r_overflow <= r_ovf_pending;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Scan side runs free of the FSM; the nibble and its blank flag are registered alongside the index.
  assign w_wrap     = (r_pre == PRE_MAX);
  assign w_idx_next = w_wrap ? (r_idx + 2'd1) : r_idx;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pre       <= '0;
      r_idx       <= 2'd0;
      r_out_value <= 4'd0;
      r_zero_hi   <= 1'b1;
    end else begin
      r_pre       <= w_wrap ? '0 : (r_pre + 1'b1);
      r_idx       <= w_idx_next;
      r_out_value <= r_display[{w_idx_next, 2'b00} +: 4];
      r_zero_hi   <= w_zero_from[w_idx_next];
    end
  end

  assign bus.o_busy        = r_busy;
  assign bus.o_overflow    = r_overflow;
  assign bus.o_digitSelect = r_idx;
  assign bus.o_value       = r_out_value;
  assign bus.o_en          = !bus.i_blankEn || (r_idx == 2'd0) || !r_zero_hi;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Randomized plus directed bench for fnd_scan_controller against a decimal-arithmetic reference model.
// All outputs are checked on every falling edge.
module tb_fnd_scan_controller;

  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fnd_scan_if bus ();

  fnd_scan_controller #(.CLK_DIV(CLK_DIV), .BIN_W(14)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: decimal value currently committed, value seen by the digit outputs,
  // remaining busy cycles, and cycles since reset for the scan position.
  int m_busy_left, m_pend, m_povf, m_disp, m_seen, m_ovf, m_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic int exp_idx();
    return (m_cyc / CLK_DIV) % 4;
  endfunction

  function automatic int exp_en();
    int k = exp_idx();
    return (!bus.i_blankEn || k == 0 || m_seen >= pow10(k)) ? 1 : 0;
  endfunction

  task automatic check_outputs();
    int k = exp_idx();
    chk("busy", 32'(bus.o_busy), 32'(m_busy_left != 0));
    chk("overflow", 32'(bus.o_overflow), 32'(m_ovf));
    chk("digit_sel", 32'(bus.o_digitSelect), 32'(k));
    chk("bcd_value", 32'(bus.o_value), 32'((m_seen / pow10(k)) % 10));
    chk("enable", 32'(bus.o_en), 32'(exp_en()));
  endtask

  task automatic model_edge();
    if (rst) begin
      m_busy_left = 0; m_disp = 0; m_seen = 0; m_ovf = 0; m_cyc = 0;
      m_pend = 0; m_povf = 0;
    end else begin
      m_seen = m_disp;
      if (m_busy_left == 0) begin
        if (bus.i_load) begin
          m_pend      = (int'(bus.i_value) > 9999) ? 9999 : int'(bus.i_value);
          m_povf      = (int'(bus.i_value) > 9999) ? 1 : 0;
          m_busy_left = 15;
        end
      end else begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_disp = m_pend;
          m_ovf  = m_povf;
        end
      end
      m_cyc++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input int v);
    bit acc;
    acc = (m_busy_left == 0) && !rst;
    bus.i_value = 14'(v);
    bus.i_load  = 1'b1;
    tick();
    bus.i_load  = 1'b0;
    $display("load value=%0d blank=%0b %s shown=%0d", v, bus.i_blankEn,
             acc ? "accepted" : "ignored", m_disp);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    ticks(n);
    rst = 1'b0;
    $display("reset for %0d cycles", n);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_value   = '0;
    bus.i_load    = 1'b0;
    bus.i_blankEn = 1'b1;
    m_busy_left = 0; m_pend = 0; m_povf = 0; m_disp = 0; m_seen = 0; m_ovf = 0; m_cyc = 0;

    do_reset(2);
    ticks(20);

    do_load(1234);
    ticks(22);

    do_load(10000);
    ticks(22);
    do_load(5);
    ticks(22);

    do_load(42);
    ticks(2);
    do_load(77);
    ticks(22);

    do_load(705);
    ticks(20);
    for (int i = 0; i < 16 && exp_idx() != 3; i++) tick();
    chk("blank_d3_on", 32'(bus.o_en), 32'(0));
    bus.i_blankEn = 1'b0;
    #1;
    chk("blank_d3_off_en", 32'(bus.o_en), 32'(1));
    chk("blank_d3_off_val", 32'(bus.o_value), 32'(0));
    $display("blank toggled to 0 on digit %0d", bus.o_digitSelect);
    ticks(8);
    bus.i_blankEn = 1'b1;

    do_load(8888);
    ticks(5);
    do_reset(1);
    ticks(40);

    for (int t = 0; t < 80; t++) begin
      int v;
      int wait_n;
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(10, 999);
        2:       v = $urandom_range(1000, 9999);
        default: v = $urandom_range(9990, 16383);
      endcase
      bus.i_blankEn = 1'($urandom_range(0, 3) != 0);
      do_load(v);
      wait_n = $urandom_range(0, 25);
      for (int i = 0; i < wait_n; i++) begin
        bus.i_value = 14'($urandom_range(0, 16383));
        bus.i_load  = 1'($urandom_range(0, 7) == 0);
        tick();
      end
      bus.i_load = 1'b0;
      if ($urandom_range(0, 14) == 0) do_reset($urandom_range(1, 2));
    end
    ticks(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
